// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, counter width and address range check for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WAIT_W = 4;
  function automatic logic in_range(input logic [31:0] addr, input int unsigned size);
    return addr < size;
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: valid/ready request and response channels of the data memory port
interface data_mem_responder_if #(
  parameter int Bits = 32,
  parameter int AddrBits = 9
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [AddrBits-1:0] req_addr;
  logic [Bits-1:0]     req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [Bits-1:0]     resp_rdata;
  logic                resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage, synchronous write, asynchronous read, no reset
module dmem_array #(
  parameter int Bits = 32,
  parameter int MemSize = 256,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [Bits-1:0] wdata,
  output logic [Bits-1:0] rdata
);
  logic [Bits-1:0] mem [MemSize];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-outstanding load/store responder with programmable wait states
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int Bits = 32,
  parameter int MemSize = 256,
  parameter int WaitStates = 2,
  parameter int AddrBits = $clog2(MemSize) + 1
) (
  input  logic clk,
  input  logic rst,
  data_mem_responder_if.slave bus,
  output logic busy
);
  localparam int AW = AddrBits - 1;
  state_t state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic wr_q;
  logic [AddrBits-1:0] addr_q;
  logic [Bits-1:0] wdata_q;
  logic cur_wr, ok, commit;
  logic [AddrBits-1:0] cur_addr;
  logic [Bits-1:0] cur_wdata, rd;
  // With zero wait states the commit edge is the accept edge, so use the live request in IDLE
  assign cur_wr    = state == IDLE ? bus.req_write : wr_q;
  assign cur_addr  = state == IDLE ? bus.req_addr  : addr_q;
  assign cur_wdata = state == IDLE ? bus.req_wdata : wdata_q;
  assign ok        = in_range(32'(cur_addr), MemSize);
  assign commit    = state != RESP && state_n == RESP;
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign busy           = state != IDLE;
  dmem_array #(.Bits(Bits), .MemSize(MemSize), .AW(AW)) u_array (
    .clk  (clk),
    .we   (commit && cur_wr && ok && !rst),
    .addr (cur_addr[AW-1:0]),
    .wdata(cur_wdata),
    .rdata(rd)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = WaitStates > 0 ? WAIT : RESP;
        cnt_n = WaitStates > 0 ? WAIT_W'(WaitStates - 1) : '0;
      end
      WAIT: begin
        state_n = cnt == 0 ? RESP : WAIT;
        cnt_n = cnt == 0 ? '0 : cnt - WAIT_W'(1);
      end
      RESP: if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && bus.req_valid) begin
        wr_q <= bus.req_write;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        bus.resp_rdata <= !cur_wr && ok ? rd : '0;
        bus.resp_err <= !ok;
      end else if (state == RESP && bus.resp_ready) begin
        bus.resp_rdata <= '0;
        bus.resp_err <= 1'b0;
      end
    end
  end
endmodule
